// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: at least one bit even for WIDTH=1.
  function automatic int cnt_width(input int width);
    int w_v;
    if (width <= 1) begin
      w_v = 1;
    end else begin
      w_v = $clog2(width);
    end
    return w_v;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full adder shared across all bit positions of the serial datapath.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: operands processed LSB-first through one full-adder
// cell, with a start/busy/done handshake and registered results.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t            state_r;
  state_t            state_nx_s;
  logic [WIDTH-1:0]  opa_r;
  logic [WIDTH-1:0]  opb_r;
  logic [WIDTH-1:0]  res_r;
  logic [WIDTH:0]    res_ext_s;
  logic [WIDTH-1:0]  res_next_s;
  logic              carry_r;
  logic [CW-1:0]     cnt_r;
  logic              fa_sum_s;
  logic              fa_cout_s;
  logic              last_bit_s;
  logic              c_msb_in_s;
  logic              busy_s;
  logic              done_s;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;

  fa_cell u_fa (
    .x    (opa_r[0]),
    .y    (opb_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // New sum bit enters at the MSB; the extended vector keeps WIDTH=1 legal.
  assign res_ext_s  = {fa_sum_s, res_r};
  assign res_next_s = res_ext_s[WIDTH:1];
  assign last_bit_s = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
  // On the final bit the carry register holds the carry into the MSB.
  assign c_msb_in_s = carry_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Handshake decode from the registered state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand capture and per-bit shifting of operands, partial result and carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_r   <= '0;
      opb_r   <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            opa_r   <= a;
            opb_r   <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            res_r   <= '0;
            cnt_r   <= '0;
          end
        end
        ST_RUN: begin
          opa_r   <= opa_r >> 1;
          opb_r   <= opb_r >> 1;
          res_r   <= res_next_s;
          carry_r <= fa_cout_s;
          cnt_r   <= cnt_r + CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers update only on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (last_bit_s) begin
      sum_r  <= res_next_s;
      cout_r <= fa_cout_s;
      ovf_r  <= c_msb_in_s ^ fa_cout_s;
    end
  end

  assign busy = busy_s;
  assign done = done_s;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_checks;
  int n_errors;

  logic [7:0] va [0:39];
  logic [7:0] vb [0:39];
  logic       vs [0:39];
  logic       vc [0:39];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic s, input logic c);
    logic [7:0] yy;
    logic       c0;
    logic [8:0] full;
    logic [7:0] low;
    yy   = s ? ~y : y;
    c0   = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yy} + {8'd0, c0};
    low  = {1'b0, x[6:0]} + {1'b0, yy[6:0]} + {7'd0, c0};
    return {low[7] ^ full[8], full[8], full[7:0]};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic icin,
                        input logic [7:0] esum, input logic ecout, input logic eovf);
    logic [7:0] prev_sum;
    int         lat;
    int         busy_cnt;
    logic       stable;
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    prev_sum = sum;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia; b = ~ib; sub = ~isub; cin = ~icin;
    lat = 21;
    busy_cnt = 0;
    stable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
      if (sum !== prev_sum) stable = 1'b0;
    end
    check({tag, " latency"}, lat, 9);
    check({tag, " busy_cycles"}, busy_cnt, 9);
    check({tag, " sum_stable_in_run"}, {31'd0, stable}, 32'd1);
    check({tag, " sum"}, {24'd0, sum}, {24'd0, esum});
    check({tag, " cout"}, {31'd0, cout}, {31'd0, ecout});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
    @(negedge clk);
    check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sum"},  {24'd0, sum},  32'd0);
    check({tag, " cout"}, {31'd0, cout}, 32'd0);
    check({tag, " ovf"},  {31'd0, ovf},  32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [9:0] exp_v;
    logic       saw_done;
    int         k0;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // Asynchronous reset pulse between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    run_op("ff_plus_ff_c1", 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Back-to-back with start held high and operands changing every cycle
    for (int k = 0; k < 40; k++) begin
      va[k] = 8'(k * 37 + 5);
      vb[k] = 8'(k * 11 + 200);
      vs[k] = (k % 3 == 0);
      vc[k] = k[0];
    end
    @(negedge clk);
    a = va[0]; b = vb[0]; sub = vs[0]; cin = vc[0]; start = 1'b1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      check("b2b done_timing", {31'd0, done}, {31'd0, (k % 10 == 9)});
      if (k % 10 == 9) begin
        k0 = k - 9;
        exp_v = ref_op(va[k0], vb[k0], vs[k0], vc[k0]);
        check("b2b result", {22'd0, ovf, cout, sum}, {22'd0, exp_v});
      end
      a = va[k]; b = vb[k]; sub = vs[k]; cin = vc[k];
      if (k == 39) start = 1'b0;
    end
    @(negedge clk);
    check("b2b end_idle", {31'd0, busy}, 32'd0);

    // Reset in the 4th RUN cycle discards the operation
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midop_rst");
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midop_rst no_done", {31'd0, saw_done}, 32'd0);
    check("midop_rst sum_zero", {24'd0, sum}, 32'd0);
    run_op("12_plus_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
